// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the combinational imem address,
// fills the IF/ID register and handles stall, flush/redirect and speculative halt.
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013),
    parameter logic [WIDTH-1:0] EBREAK   = WIDTH'(32'h0010_0073)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] ifid_instr_o,
    output logic [WIDTH-1:0] ifid_pc_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [31:0]      fetch_count_o
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ifid_instr;
    logic [WIDTH-1:0] r_ifid_pc;
    logic             r_ifid_valid;
    logic             r_halted;
    logic             r_fault;
    logic [31:0]      r_fetch_count;

    logic             w_in_range;

    assign w_in_range = ({2'b00, r_pc[WIDTH-1:2]} < WIDTH'(DEPTH));

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP;
            r_ifid_pc     <= '0;
            r_ifid_valid  <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect_i) begin
            // Wrong-path word on imem_data_i is dropped; ifid_pc is left as is.
            r_state      <= ST_RUN;
            r_pc         <= {redirect_pc_i[WIDTH-1:2], 2'b00};
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
            r_halted     <= 1'b0;
            r_fault      <= 1'b0;
        end else if (r_state == ST_HALT) begin
            // Stall is ignored here: keep draining bubbles with the PC frozen.
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
        end else if (!stall_i) begin
            if (!w_in_range) begin
                r_state      <= ST_HALT;
                r_ifid_instr <= NOP;
                r_ifid_pc    <= r_pc;
                r_ifid_valid <= 1'b0;
                r_halted     <= 1'b1;
                r_fault      <= 1'b1;
            end else if (imem_data_i == EBREAK) begin
                r_state       <= ST_HALT;
                r_ifid_instr  <= imem_data_i;
                r_ifid_pc     <= r_pc;
                r_ifid_valid  <= 1'b1;
                r_halted      <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_pc          <= r_pc + WIDTH'(4);
                r_ifid_instr  <= imem_data_i;
                r_ifid_pc     <= r_pc;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr_o   = r_pc;
    assign ifid_instr_o  = r_ifid_instr;
    assign ifid_pc_o     = r_ifid_pc;
    assign ifid_valid_o  = r_ifid_valid;
    assign halted_o      = r_halted;
    assign fault_o       = r_fault;
    assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a DEPTH=64 instance runs the main sequence,
// a DEPTH=4 instance exercises the fall-off-the-end fault path.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] I0     = 32'h0050_0493;
    localparam logic [31:0] I1     = 32'h0010_0513;
    localparam logic [31:0] I2     = 32'h0020_0593;
    localparam logic [31:0] I3     = 32'h0030_0613;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A (DEPTH=64)
    logic        rst_a, stall_a, redir_a;
    logic [31:0] redir_pc_a, addr_a, data_a, instr_a, ipc_a, cnt_a;
    logic        valid_a, halted_a, fault_a;
    logic [31:0] mem_a [0:63];

    assign data_a = (addr_a[31:8] == 24'd0) ? mem_a[addr_a[7:2]] : NOP;

    fetch_ctrl #(.WIDTH(32), .DEPTH(64)) u_dut_a (
        .clk(clk), .rst(rst_a), .stall_i(stall_a), .redirect_i(redir_a),
        .redirect_pc_i(redir_pc_a), .imem_addr_o(addr_a), .imem_data_i(data_a),
        .ifid_instr_o(instr_a), .ifid_pc_o(ipc_a), .ifid_valid_o(valid_a),
        .halted_o(halted_a), .fault_o(fault_a), .fetch_count_o(cnt_a)
    );

    // Instance B (DEPTH=4), memory is all NOPs
    logic        rst_b, redir_b;
    logic [31:0] redir_pc_b, addr_b, instr_b, ipc_b, cnt_b;
    logic        valid_b, halted_b, fault_b;

    fetch_ctrl #(.WIDTH(32), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .stall_i(1'b0), .redirect_i(redir_b),
        .redirect_pc_i(redir_pc_b), .imem_addr_o(addr_b), .imem_data_i(NOP),
        .ifid_instr_o(instr_b), .ifid_pc_o(ipc_b), .ifid_valid_o(valid_b),
        .halted_o(halted_b), .fault_o(fault_b), .fetch_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                         input logic [31:0] ins, input logic v, input logic h, input logic [31:0] c);
        check({tag, ".addr"},   addr_a,   pc);
        check({tag, ".ifpc"},   ipc_a,    ipc);
        check({tag, ".instr"},  instr_a,  ins);
        check({tag, ".valid"},  32'(valid_a),  32'(v));
        check({tag, ".halted"}, 32'(halted_a), 32'(h));
        check({tag, ".count"},  cnt_a,    c);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = NOP;
        mem_a[0] = I0; mem_a[1] = I1; mem_a[2] = I2; mem_a[3] = I3; mem_a[4] = EBREAK;

        rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; redir_pc_a = '0;
        rst_b = 1'b1; redir_b = 1'b0; redir_pc_b = '0;
        #2;
        step(); step();
        chk_a("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        check("reset.fault", 32'(fault_a), 32'd0);

        // Normal fetch: 0, 4
        rst_a = 1'b0;
        step(); chk_a("run0", 32'h4, 32'h0, I0, 1'b1, 1'b0, 32'd1);
        step(); chk_a("run1", 32'h8, 32'h4, I1, 1'b1, 1'b0, 32'd2);

        // Two-cycle stall holds everything
        stall_a = 1'b1;
        step(); chk_a("stall0", 32'h8, 32'h4, I1, 1'b1, 1'b0, 32'd2);
        step(); chk_a("stall1", 32'h8, 32'h4, I1, 1'b1, 1'b0, 32'd2);
        stall_a = 1'b0;
        step(); chk_a("resume", 32'hC, 32'h8, I2, 1'b1, 1'b0, 32'd3);

        // Redirect to 0x5 -> 0x4, then to 0x0D -> 0xC while PC=8
        redir_a = 1'b1; redir_pc_a = 32'h5;
        step(); chk_a("redir5", 32'h4, 32'h8, NOP, 1'b0, 1'b0, 32'd3);
        redir_a = 1'b0;
        step(); chk_a("tgt4", 32'h8, 32'h4, I1, 1'b1, 1'b0, 32'd4);
        redir_a = 1'b1; redir_pc_a = 32'h0D;
        step(); chk_a("redirD", 32'hC, 32'h4, NOP, 1'b0, 1'b0, 32'd4);
        redir_a = 1'b0;
        step(); chk_a("tgtC", 32'h10, 32'hC, I3, 1'b1, 1'b0, 32'd5);

        // EBREAK at 0x10
        step(); chk_a("ebreak", 32'h10, 32'h10, EBREAK, 1'b1, 1'b1, 32'd6);
        check("ebreak.fault", 32'(fault_a), 32'd0);
        stall_a = 1'b1;
        step();
        check("bub0.addr",  addr_a, 32'h10);
        check("bub0.instr", instr_a, NOP);
        check("bub0.valid", 32'(valid_a), 32'd0);
        check("bub0.halt",  32'(halted_a), 32'd1);
        stall_a = 1'b0;
        step();
        check("bub1.addr",  addr_a, 32'h10);
        check("bub1.valid", 32'(valid_a), 32'd0);
        check("bub1.count", cnt_a, 32'd6);

        // Redirect out of HALT to 0x4
        redir_a = 1'b1; redir_pc_a = 32'h4;
        step();
        check("unhalt.halt", 32'(halted_a), 32'd0);
        check("unhalt.addr", addr_a, 32'h4);
        check("unhalt.valid", 32'(valid_a), 32'd0);
        redir_a = 1'b0;
        step(); chk_a("refetch4", 32'h8, 32'h4, I1, 1'b1, 1'b0, 32'd7);

        // Redirect + stall + EBREAK all in one cycle
        redir_a = 1'b1; redir_pc_a = 32'h10;
        step(); check("toE.addr", addr_a, 32'h10);
        check("toE.data", data_a, EBREAK);
        redir_pc_a = 32'h0; stall_a = 1'b1;
        step(); chk_a("combo", 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'd7);
        redir_a = 1'b0; stall_a = 1'b0;
        step(); chk_a("combo.next", 32'h4, 32'h0, I0, 1'b1, 1'b0, 32'd8);

        // Reset while halted on EBREAK
        redir_a = 1'b1; redir_pc_a = 32'h10;
        step(); redir_a = 1'b0;
        step(); check("pre_rst.halt", 32'(halted_a), 32'd1);
        rst_a = 1'b1;
        step(); chk_a("midrst", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        rst_a = 1'b0;

        // Instance B: fall off the end of a 4-word memory
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("b.pre.ifpc", ipc_b, 32'hC);
        check("b.pre.count", cnt_b, 32'd4);
        check("b.pre.halt", 32'(halted_b), 32'd0);
        step();
        check("b.oor.halt",  32'(halted_b), 32'd1);
        check("b.oor.fault", 32'(fault_b), 32'd1);
        check("b.oor.valid", 32'(valid_b), 32'd0);
        check("b.oor.instr", instr_b, NOP);
        check("b.oor.ifpc",  ipc_b, 32'h10);
        check("b.oor.addr",  addr_b, 32'h10);
        check("b.oor.count", cnt_b, 32'd4);
        step();
        check("b.hold.fault", 32'(fault_b), 32'd1);
        check("b.hold.addr",  addr_b, 32'h10);

        // Redirect clears fault and restarts at 0x8
        redir_b = 1'b1; redir_pc_b = 32'hA;
        step(); redir_b = 1'b0;
        check("b.redir.fault", 32'(fault_b), 32'd0);
        check("b.redir.halt",  32'(halted_b), 32'd0);
        check("b.redir.addr",  addr_b, 32'h8);
        step(); step(); step();
        check("b.refault", 32'(fault_b), 32'd1);
        check("b.refault.count", cnt_b, 32'd6);

        // Reset clears both flags and the PC
        rst_b = 1'b1;
        step();
        check("b.rst.halt",  32'(halted_b), 32'd0);
        check("b.rst.fault", 32'(fault_b), 32'd0);
        check("b.rst.addr",  addr_b, 32'h0);
        check("b.rst.count", cnt_b, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the pipelined RISC-V core. It owns the program counter and drives the combinational instruction memory's read address. It captures the returned word into the IF/ID register and applies stall, flush and redirect requests from the hazard logic. It also stops fetching speculatively on EBREAK or when the PC runs past the end of memory.

## Interface
- WIDTH, 32, data/address width
- DEPTH, 64, instruction memory depth in words
- RESET_PC, 0, PC loaded on reset
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0)
- EBREAK, 32'h00100073, encoding that triggers halt

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  load-use stall from ID; hold PC and IF/ID
- redirect_i  in  1  taken branch/jump resolved in EX
- redirect_pc_i  in  WIDTH  target address; bits [1:0] ignored (forced 0)
- imem_addr_o  out  WIDTH  read address to instruction memory (= PC)
- imem_data_i  in  WIDTH  instruction word returned combinationally
- ifid_instr_o  out  WIDTH  IF/ID instruction register
- ifid_pc_o  out  WIDTH  IF/ID PC register
- ifid_valid_o  out  1  IF/ID holds a real (non-bubble) instruction
- halted_o  out  1  controller in HALT state
- fault_o  out  1  sticky: halt caused by out-of-range PC
- fetch_count_o  out  32  count of instructions accepted into IF/ID, wraps at 2^32

## Operation
- State machine with two states, RUN and HALT. Reset enters RUN.
- Per-cycle priority is rst > redirect_i > stall_i > halt detection > normal advance.
- rst:
  - PC=RESET_PC, ifid_instr=NOP, ifid_pc=0, ifid_valid=0.
  - halted_o=0, fault_o=0, fetch_count=0.
- redirect_i, in either state:
  - PC = {redirect_pc_i[WIDTH-1:2],2'b00}.
  - IF/ID flushed: instr=NOP, valid=0, ifid_pc unchanged.
  - State becomes RUN, fault_o cleared.
  - The wrong-path instruction currently at imem_data_i is discarded.
- stall_i in RUN with no redirect: PC, IF/ID and counter all hold.
- Normal RUN cycle:
  - Compute in_range = (PC>>2) < DEPTH.
  - If in_range and imem_data_i != EBREAK:
    - IF/ID = {imem_data_i, PC, valid=1}.
    - PC += 4.
    - fetch_count += 1.
  - If in_range and imem_data_i == EBREAK:
    - IF/ID = {EBREAK, PC, valid=1}, fetch_count += 1.
    - PC holds, next state HALT.
  - If not in_range:
    - IF/ID = {NOP, PC, valid=0}, PC holds.
    - fault_o=1, next state HALT.
- HALT:
  - PC frozen. Each cycle IF/ID gets instr=NOP, valid=0 (bubbles drain the pipe).
  - stall_i has no effect in HALT.
  - Only redirect_i (older in-flight branch, so the halt was speculative) or rst leaves HALT.
- PC arithmetic is modulo 2^WIDTH; wrap to 0 is permitted, then fetch continues.
- imem_addr_o = PC at all times, including HALT.

## Timing
- Memory read is combinational: the instruction at PC is captured into IF/ID on the same rising edge that advances PC. Fetch latency is 1 cycle.
- First edge after rst deasserts captures Mem[RESET_PC>>2]; ifid_valid_o rises one cycle after release.
- Redirect penalty: the IF/ID bubble appears on the edge after redirect_i. The target instruction appears in IF/ID one edge later.
- EBREAK: halted_o rises on the edge that captures EBREAK. The next edge produces the first bubble.
- redirect_i together with stall_i: redirect wins, stall ignored that cycle.
- redirect_i in the same cycle that EBREAK or out-of-range is seen: redirect wins and HALT is not entered.
- rst asserted mid-stream or mid-HALT: all outputs return to reset values on that edge.
- All outputs are registered except imem_addr_o, which is the PC register itself.

## Test plan
- Reset then run with Mem = {addi x9,x0,5; addi x10,x0,1; NOP…}:
  - ifid_pc sequence 0,4,8.
  - ifid_instr 0x00500493, 0x00100513.
  - fetch_count 1,2,3.
- stall_i high 2 cycles while ifid_pc=4: IF/ID and imem_addr_o hold at 4/8 for 2 cycles, then resume at 8, with no count increment during the stall.
- redirect_i=1, redirect_pc_i=0x0D while PC=0x8:
  - Next edge: ifid_valid=0, instr=0x00000013, PC=0xC.
  - Following edge: ifid_pc=0xC, valid=1.
- EBREAK at address 0x10:
  - halted_o=1 with ifid_instr=0x00100073.
  - Bubbles thereafter, imem_addr_o stuck at 0x10.
  - redirect_i to 0x4 restores RUN and fetches from 0x4.
- Fall off end with DEPTH=4 and no EBREAK:
  - At PC=0x10, halted_o=1, fault_o=1, valid=0.
  - rst clears both flags and PC returns to 0.
- redirect_i, stall_i and EBREAK all in the same cycle: redirect taken, no halt, no stall, bubble inserted.
